bresenham_circle_engine: RTL and testbench

BRESENHAM_CIRCLE_ENGINE -- requirements
Module: bresenham_circle_engine

---
 rtl/bresenham_circle_engine_pkg.sv | 17 +
 rtl/bresenham_circle_engine_octant_map.sv | 47 ++++
 rtl/bresenham_circle_engine.sv | 175 +++++++++++++++++
 tb/tb_bresenham_circle_engine.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bresenham_circle_engine_pkg.sv
// Shared definitions for the Bresenham circle engine: FSM encoding and the
// per-octant swap/sign table used to map (x,y) onto the eight symmetric points.
package bresenham_circle_engine_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EMIT   = 2'd1,
    S_STEP   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  // Bit k describes octant k: swap x/y, negate the horizontal term, negate the vertical term.
  localparam logic [7:0] OCT_SWAP  = 8'b0110_0110;
  localparam logic [7:0] OCT_NEG_X = 8'b0011_1100;
  localparam logic [7:0] OCT_NEG_Y = 8'b1111_0000;

endpackage

// File: rtl/bresenham_circle_engine_octant_map.sv
// Combinational octant mapper: (cx,cy,x,y,k) -> screen candidate plus clip flag.
module circle_octant_map
  import bresenham_circle_engine_pkg::*;
#(
  parameter int COORD_W = 10,
  parameter int RAD_W   = 9,
  parameter int H_RES   = 640,
  parameter int V_RES   = 480
) (
  input  logic [COORD_W-1:0] i_cx,
  input  logic [COORD_W-1:0] i_cy,
  input  logic [RAD_W-1:0]   i_x,
  input  logic [RAD_W-1:0]   i_y,
  input  logic [2:0]         i_k,
  output logic [COORD_W-1:0] o_px,
  output logic [COORD_W-1:0] o_py,
  output logic               o_clipped
);

  localparam int CW2 = COORD_W + 2;
  localparam logic signed [CW2-1:0] H_LIM = CW2'(H_RES);
  localparam logic signed [CW2-1:0] V_LIM = CW2'(V_RES);

  logic [RAD_W-1:0]      w_a;
  logic [RAD_W-1:0]      w_b;
  logic signed [CW2-1:0] w_cx;
  logic signed [CW2-1:0] w_cy;
  logic signed [CW2-1:0] w_da;
  logic signed [CW2-1:0] w_db;
  logic signed [CW2-1:0] w_px;
  logic signed [CW2-1:0] w_py;

  assign w_a  = OCT_SWAP[i_k] ? i_y : i_x;
  assign w_b  = OCT_SWAP[i_k] ? i_x : i_y;
  assign w_cx = $signed({2'b00, i_cx});
  assign w_cy = $signed({2'b00, i_cy});
  assign w_da = $signed(CW2'(w_a));
  assign w_db = $signed(CW2'(w_b));

  assign w_px = OCT_NEG_X[i_k] ? (w_cx - w_da) : (w_cx + w_da);
  assign w_py = OCT_NEG_Y[i_k] ? (w_cy - w_db) : (w_cy + w_db);

  assign o_px      = w_px[COORD_W-1:0];
  assign o_py      = w_py[COORD_W-1:0];
  assign o_clipped = w_px[CW2-1] || (w_px >= H_LIM) || w_py[CW2-1] || (w_py >= V_LIM);

endmodule

// File: rtl/bresenham_circle_engine.sv
// Midpoint/Bresenham circle rasteriser emitting clipped, octant-masked pixels
// over a registered valid/ready stream.
module bresenham_circle_engine
  import bresenham_circle_engine_pkg::*;
#(
  parameter int COORD_W = 10,
  parameter int RAD_W   = 9,
  parameter int H_RES   = 640,
  parameter int V_RES   = 480
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COORD_W-1:0] cx,
  input  logic [COORD_W-1:0] cy,
  input  logic [RAD_W-1:0]   radius,
  input  logic [7:0]         oct_mask,
  output logic               busy,
  output logic               done,
  output logic [COORD_W-1:0] px,
  output logic [COORD_W-1:0] py,
  output logic               pix_valid,
  input  logic               pix_ready
);

  localparam int DW = RAD_W + 3;
  localparam logic signed [DW-1:0] D_THREE = DW'(3);
  localparam logic signed [DW-1:0] D_SIX   = DW'(6);
  localparam logic signed [DW-1:0] D_TEN   = DW'(10);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [COORD_W-1:0]    r_cx;
  logic [COORD_W-1:0]    r_cy;
  logic [7:0]            r_mask;
  logic                  r_zero;
  logic [RAD_W-1:0]      r_x;
  logic [RAD_W-1:0]      r_y;
  logic signed [DW-1:0]  r_d;
  logic [2:0]            r_oct;
  logic [COORD_W-1:0]    r_px;
  logic [COORD_W-1:0]    r_py;
  logic                  r_valid;

  logic [COORD_W-1:0]    w_cand_x;
  logic [COORD_W-1:0]    w_cand_y;
  logic                  w_clip;
  logic                  w_skip;
  logic                  w_accept;
  logic                  w_load;
  logic                  w_adv;
  logic                  w_step;
  logic [RAD_W-1:0]      w_x_nxt;
  logic [RAD_W-1:0]      w_y_nxt;
  logic signed [DW-1:0]  w_d_nxt;
  logic signed [DW-1:0]  w_xs;
  logic signed [DW-1:0]  w_ys;
  logic signed [DW-1:0]  w_d_init;

  circle_octant_map #(
    .COORD_W (COORD_W),
    .RAD_W   (RAD_W),
    .H_RES   (H_RES),
    .V_RES   (V_RES)
  ) u_map (
    .i_cx      (r_cx),
    .i_cy      (r_cy),
    .i_x       (r_x),
    .i_y       (r_y),
    .i_k       (r_oct),
    .o_px      (w_cand_x),
    .o_py      (w_cand_y),
    .o_clipped (w_clip)
  );

  assign w_skip   = !r_mask[r_oct] || w_clip;
  assign w_d_init = D_THREE - $signed(DW'({radius, 1'b0}));

  always_comb begin
    w_xs    = $signed(DW'(r_x));
    w_ys    = $signed(DW'(r_y));
    w_x_nxt = r_x + RAD_W'(1);
    if (r_d[DW-1]) begin
      w_d_nxt = r_d + (w_xs <<< 2) + D_SIX;
      w_y_nxt = r_y;
    end else begin
      w_d_nxt = r_d + ((w_xs - w_ys) <<< 2) + D_TEN;
      w_y_nxt = r_y - RAD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // A pixel costs a load cycle plus the handshake; pix_ready only ever reaches registers.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    w_adv       = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_EMIT;
        end
      end
      S_EMIT: begin
        if (r_valid)     w_adv  = pix_ready;
        else if (w_skip) w_adv  = 1'b1;
        else             w_load = 1'b1;
        // A zero radius collapses all octants onto the centre, so only octant 0 is visited.
        if (w_adv && (r_zero || (r_oct == 3'd7)))
          w_state_nxt = r_zero ? S_FINISH : S_STEP;
      end
      S_STEP: begin
        w_step      = 1'b1;
        w_state_nxt = (w_x_nxt <= w_y_nxt) ? S_EMIT : S_FINISH;
      end
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cx    <= '0;
      r_cy    <= '0;
      r_mask  <= '0;
      r_zero  <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_d     <= '0;
      r_oct   <= '0;
      r_px    <= '0;
      r_py    <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cx   <= cx;
        r_cy   <= cy;
        r_mask <= oct_mask;
        r_zero <= (radius == '0);
        r_x    <= '0;
        r_y    <= radius;
        r_d    <= w_d_init;
        r_oct  <= '0;
      end
      if (w_load) begin
        r_px    <= w_cand_x;
        r_py    <= w_cand_y;
        r_valid <= 1'b1;
      end
      if (w_adv) begin
        r_valid <= 1'b0;
        r_oct   <= r_oct + 3'd1;
      end
      if (w_step) begin
        r_x <= w_x_nxt;
        r_y <= w_y_nxt;
        r_d <= w_d_nxt;
      end
    end
  end

  assign busy      = (r_state == S_EMIT) || (r_state == S_STEP);
  assign done      = (r_state == S_FINISH);
  assign px        = r_px;
  assign py        = r_py;
  assign pix_valid = r_valid;

endmodule

// File: tb/tb_bresenham_circle_engine.sv
// Self-checking bench for bresenham_circle_engine: integer circle model plus
// directed scenarios with hand-computed pixel counts and sequences.
module tb_bresenham_circle_engine;

  localparam int COORD_W = 10;
  localparam int RAD_W   = 9;
  localparam int H_RES   = 640;
  localparam int V_RES   = 480;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic [COORD_W-1:0] cx = '0;
  logic [COORD_W-1:0] cy = '0;
  logic [RAD_W-1:0]   radius = '0;
  logic [7:0]         oct_mask = '0;
  logic               busy;
  logic               done;
  logic [COORD_W-1:0] px;
  logic [COORD_W-1:0] py;
  logic               pix_valid;
  logic               pix_ready;

  always #5 clk = ~clk;

  bresenham_circle_engine #(
    .COORD_W (COORD_W),
    .RAD_W   (RAD_W),
    .H_RES   (H_RES),
    .V_RES   (V_RES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cx        (cx),
    .cy        (cy),
    .radius    (radius),
    .oct_mask  (oct_mask),
    .busy      (busy),
    .done      (done),
    .px        (px),
    .py        (py),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready)
  );

  typedef struct {int x; int y;} pt_t;

  int  checks = 0;
  int  failures = 0;
  pt_t exp_q[$];
  pt_t got_q[$];
  pt_t ref_q[$];
  bit  mon_en = 1'b0;
  bit  bp_en = 1'b0;
  int  done_cnt = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference circle: the textbook midpoint recurrence on plain integers.
  task automatic build_model(input int c_x, input int c_y, input int r, input logic [7:0] m);
    int x, y, d, qx, qy;
    exp_q.delete();
    if (r == 0) begin
      if (m[0] && c_x < H_RES && c_y < V_RES) exp_q.push_back('{c_x, c_y});
      return;
    end
    x = 0; y = r; d = 3 - 2 * r;
    while (x <= y) begin
      for (int k = 0; k < 8; k++) begin
        case (k)
          0: begin qx = c_x + x; qy = c_y + y; end
          1: begin qx = c_x + y; qy = c_y + x; end
          2: begin qx = c_x - y; qy = c_y + x; end
          3: begin qx = c_x - x; qy = c_y + y; end
          4: begin qx = c_x - x; qy = c_y - y; end
          5: begin qx = c_x - y; qy = c_y - x; end
          6: begin qx = c_x + y; qy = c_y - x; end
          default: begin qx = c_x + x; qy = c_y - y; end
        endcase
        if (m[k] && qx >= 0 && qx < H_RES && qy >= 0 && qy < V_RES)
          exp_q.push_back('{qx, qy});
      end
      if (d < 0) d = d + 4 * x + 6;
      else begin d = d + 4 * (x - y) + 10; y = y - 1; end
      x = x + 1;
    end
  endtask

  initial begin
    pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      pix_ready = bp_en ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  logic               stall_prev = 1'b0;
  logic [COORD_W-1:0] spx = '0;
  logic [COORD_W-1:0] spy = '0;

  always @(negedge clk) begin
    pt_t e;
    if (mon_en) begin
      if (done) done_cnt++;
      if (stall_prev) begin
        check("stall_valid", int'(pix_valid), 1);
        check("stall_px", int'(px), int'(spx));
        check("stall_py", int'(py), int'(spy));
      end
      if (pix_valid && pix_ready) begin
        got_q.push_back('{int'(px), int'(py)});
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL extra_pixel actual=(%0d,%0d) required=none", px, py);
        end else begin
          e = exp_q.pop_front();
          if (int'(px) != e.x || int'(py) != e.y) begin
            failures++;
            $display("FAIL pixel actual=(%0d,%0d) required=(%0d,%0d)", px, py, e.x, e.y);
          end
        end
      end
      stall_prev = pix_valid && !pix_ready;
      spx = px;
      spy = py;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic draw(input int c_x, input int c_y, input int r, input logic [7:0] m,
                      input int exp_n, input bit inject, input bit fin_start);
    bit seen;
    build_model(c_x, c_y, r, m);
    check("model_count", exp_q.size(), exp_n);
    got_q.delete();
    done_cnt = 0;
    mon_en = 1'b1;
    @(posedge clk); #1;
    cx = COORD_W'(c_x); cy = COORD_W'(c_y); radius = RAD_W'(r); oct_mask = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    if (inject) begin
      repeat (5) @(posedge clk);
      #1;
      cx = 10'd7; cy = 10'd7; radius = 9'd1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL done_timeout actual=no_done required=done");
    end
    check("busy_low_at_done", int'(busy), 0);
    if (fin_start) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin
        @(negedge clk);
        check("finish_start_ignored", int'(busy), 0);
      end
    end
    repeat (2) @(negedge clk);
    check("done_pulses", done_cnt, 1);
    check("missing_pixels", exp_q.size(), 0);
    check("pixel_count", got_q.size(), exp_n);
  endtask

  task automatic check_r1_literal();
    int ex_x[8] = '{100, 101, 99, 100, 100, 99, 101, 100};
    int ex_y[8] = '{101, 100, 100, 101, 99, 100, 100, 99};
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      check("r1_lit_x", got_q[i].x, ex_x[i]);
      check("r1_lit_y", got_q[i].y, ex_y[i]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_valid"}, int'(pix_valid), 0);
    check({tag, "_px"}, int'(px), 0);
    check({tag, "_py"}, int'(py), 0);
  endtask

  initial begin
    int bad;
    #1;
    check_reset_outputs("por");
    #21 rst = 1'b1;

    draw(100, 100, 1, 8'hFF, 8, 1'b0, 1'b0);
    check_r1_literal();

    draw(320, 240, 3, 8'hFF, 24, 1'b1, 1'b1);
    ref_q = got_q;

    draw(5, 5, 0, 8'hFF, 1, 1'b0, 1'b0);
    if (got_q.size() > 0) begin
      check("r0_px", got_q[0].x, 5);
      check("r0_py", got_q[0].y, 5);
    end
    draw(5, 5, 0, 8'hFE, 0, 1'b0, 1'b0);

    draw(0, 0, 5, 8'hFF, 10, 1'b0, 1'b0);
    bad = 0;
    foreach (got_q[i]) if (got_q[i].x > 5 || got_q[i].y > 5) bad++;
    check("clip_out_of_range", bad, 0);

    bp_en = 1'b1;
    draw(320, 240, 3, 8'hFF, 24, 1'b0, 1'b0);
    bp_en = 1'b0;
    check("bp_len", got_q.size(), ref_q.size());
    for (int i = 0; i < got_q.size() && i < ref_q.size(); i++) begin
      check("bp_seq_x", got_q[i].x, ref_q[i].x);
      check("bp_seq_y", got_q[i].y, ref_q[i].y);
    end

    mon_en = 1'b0;
    @(posedge clk); #1;
    cx = 10'd320; cy = 10'd240; radius = 9'd50; oct_mask = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("mid_draw_busy", int'(busy), 1);
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    draw(100, 100, 1, 8'hFF, 8, 1'b0, 1'b0);
    check_r1_literal();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
